// File: rtl/reorder_returner_pkg.sv
// Shared types and sizing helpers for the in-order completion stage.
// RETURNER_CHECK_EN (optional) enables duplicate-arrival detection in the channels.
package types_def;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } request_type_t;

    localparam int DEFAULT_DATA_WIDTH    = 16;
    localparam int DEFAULT_READ_ENTRIES  = 64;
    localparam int DEFAULT_WRITE_ENTRIES = 64;

    // Shared tag width: wide enough for the deeper of the two reorder windows.
    function automatic int idx_width(input int read_entries, input int write_entries);
        return $clog2((read_entries > write_entries) ? read_entries : write_entries);
    endfunction

endpackage

// File: rtl/reorder_returner_channel.sv
// One reorder window: slot array, head pointer and a single output register.
// With RETURNER_CHECK_EN defined, adds the sticky err_dup flag and a duplicate-arrival assertion.
module reorder_channel
    import types_def::*;
#(
    parameter int  ENTRIES     = DEFAULT_READ_ENTRIES,
    parameter int  PAYLOAD_W   = DEFAULT_DATA_WIDTH,
    parameter bit  HAS_PAYLOAD = 1'b1,
    localparam int IW          = $clog2(ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [IW-1:0]        in_index,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [IW-1:0]        out_index,
    output logic [IW-1:0]        head
`ifdef RETURNER_CHECK_EN
    ,
    output logic                 err_dup
`endif
);

    // Handshake: a completion transfers on a rising edge where out_valid && out_ready;
    // out_valid never drops and out_data/out_index never change until that transfer.

    logic [ENTRIES-1:0] slot_valid;
    logic [ENTRIES-1:0] slot_valid_next;
    logic               bypass;
    logic               present;
    logic               out_free;
    logic               retire;

    always_comb begin
        bypass          = in_valid && (in_index == head);
        present         = slot_valid[head] || bypass;
        out_free        = !out_valid || out_ready;
        retire          = out_free && present;
        slot_valid_next = slot_valid;
        if (in_valid) begin
            slot_valid_next[in_index] = 1'b1;
        end
        // Clearing wins so a bypassed arrival never lingers in its slot.
        if (retire) begin
            slot_valid_next[head] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= '0;
            head       <= '0;
            out_valid  <= 1'b0;
            out_index  <= '0;
        end else begin
            slot_valid <= slot_valid_next;
            if (retire) begin
                head      <= head + IW'(1);
                out_index <= head;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    generate
        if (HAS_PAYLOAD) begin : g_payload
            logic [PAYLOAD_W-1:0] slot_data [ENTRIES];
            logic [PAYLOAD_W-1:0] retire_data;

            always_ff @(posedge clk) begin
                if (in_valid) begin
                    slot_data[in_index] <= in_data;
                end
            end

            // A same-cycle arrival at head is the newest copy of that entry.
            assign retire_data = bypass ? in_data : slot_data[head];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_data <= '0;
                end else if (retire) begin
                    out_data <= retire_data;
                end
            end
        end else begin : g_no_payload
            logic unused_in_data;
            assign unused_in_data = ^in_data;
            assign out_data       = '0;
        end
    endgenerate

`ifdef RETURNER_CHECK_EN
    // A slot being retired without bypass is still marked valid, so one test covers both cases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_dup <= 1'b0;
        end else if (in_valid && slot_valid[in_index]) begin
            err_dup <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rst_n && in_valid) begin
            assert (!slot_valid[in_index])
            else $warning("reorder_channel: duplicate arrival at index %0d", in_index);
        end
    end
`endif

endmodule

// File: rtl/reorder_returner.sv
// In-order completion stage: independent read and write reorder channels fed by one tagged input.
// RETURNER_CHECK_EN (optional) adds the sticky err_dup output.
module reorder_returner
    import types_def::*;
#(
    parameter int  DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int  READ_ENTRIES  = DEFAULT_READ_ENTRIES,
    parameter int  WRITE_ENTRIES = DEFAULT_WRITE_ENTRIES,
    localparam int IDX_W         = idx_width(READ_ENTRIES, WRITE_ENTRIES),
    localparam int RD_W          = $clog2(READ_ENTRIES),
    localparam int WR_W          = $clog2(WRITE_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  request_type_t         in_type,
    input  logic [IDX_W-1:0]      in_index,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [RD_W-1:0]       rd_index,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [WR_W-1:0]       wr_index,
    output logic [RD_W-1:0]       rd_head,
    output logic [WR_W-1:0]       wr_head
`ifdef RETURNER_CHECK_EN
    ,
    output logic                  err_dup
`endif
);

    logic rd_in_valid;
    logic wr_in_valid;
    logic wr_data_unused;

    assign rd_in_valid = in_valid && (in_type == REQ_READ);
    assign wr_in_valid = in_valid && (in_type == REQ_WRITE);

`ifdef RETURNER_CHECK_EN
    logic rd_err_dup;
    logic wr_err_dup;
    assign err_dup = rd_err_dup || wr_err_dup;
`endif

    reorder_channel #(
        .ENTRIES     (READ_ENTRIES),
        .PAYLOAD_W   (DATA_WIDTH),
        .HAS_PAYLOAD (1'b1)
    ) u_read (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_in_valid),
        .in_index  (in_index[RD_W-1:0]),
        .in_data   (in_data),
        .out_valid (rd_valid),
        .out_ready (rd_ready),
        .out_data  (rd_data),
        .out_index (rd_index),
        .head      (rd_head)
`ifdef RETURNER_CHECK_EN
        ,
        .err_dup   (rd_err_dup)
`endif
    );

    // Writes carry no payload; the one-bit data port is tied off.
    reorder_channel #(
        .ENTRIES     (WRITE_ENTRIES),
        .PAYLOAD_W   (1),
        .HAS_PAYLOAD (1'b0)
    ) u_write (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (wr_in_valid),
        .in_index  (in_index[WR_W-1:0]),
        .in_data   (1'b0),
        .out_valid (wr_valid),
        .out_ready (wr_ready),
        .out_data  (wr_data_unused),
        .out_index (wr_index),
        .head      (wr_head)
`ifdef RETURNER_CHECK_EN
        ,
        .err_dup   (wr_err_dup)
`endif
    );

endmodule

// File: tb/tb_reorder_returner.sv
// Directed bench for reorder_returner with a per-channel expected queue.
// Builds with or without RETURNER_CHECK_EN.
module tb_reorder_returner;
    import types_def::*;

    localparam int DW    = 16;
    localparam int RE    = 4;
    localparam int WE    = 8;
    localparam int IDX_W = 3;
    localparam int RD_W  = 2;
    localparam int WR_W  = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    request_type_t        in_type;
    logic [IDX_W-1:0]     in_index;
    logic [DW-1:0]        in_data;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [DW-1:0]        rd_data;
    logic [RD_W-1:0]      rd_index;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [WR_W-1:0]      wr_index;
    logic [RD_W-1:0]      rd_head;
    logic [WR_W-1:0]      wr_head;
`ifdef RETURNER_CHECK_EN
    logic                 err_dup;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [RD_W+DW-1:0] rd_exp_q[$];
    logic [WR_W-1:0]    wr_exp_q[$];

    reorder_returner #(
        .DATA_WIDTH    (DW),
        .READ_ENTRIES  (RE),
        .WRITE_ENTRIES (WE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_type  (in_type),
        .in_index (in_index),
        .in_data  (in_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_index (rd_index),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_index (wr_index),
        .rd_head  (rd_head),
        .wr_head  (wr_head)
`ifdef RETURNER_CHECK_EN
        ,
        .err_dup  (err_dup)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input request_type_t t, input int idx, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_type  = t;
        in_index = IDX_W'(idx);
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_rd(input int idx, input logic [DW-1:0] d);
        rd_exp_q.push_back({RD_W'(idx), d});
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((rd_exp_q.size() != 0 || wr_exp_q.size() != 0) && n < max_cycles) begin
            step();
            n++;
        end
        chk("drain_rd_q", 32'(rd_exp_q.size()), 32'd0);
        chk("drain_wr_q", 32'(wr_exp_q.size()), 32'd0);
    endtask

    // Scoreboard: compare every accepted completion against the expected queue.
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) begin
            vectors++;
            assert (rd_exp_q.size() != 0)
            else begin
                miscompares++;
                $error("FAIL rd_unexpected observed=%0h expected=none", {rd_index, rd_data});
            end
            if (rd_exp_q.size() != 0) begin
                logic [RD_W+DW-1:0] e;
                e = rd_exp_q.pop_front();
                vectors++;
                assert ({rd_index, rd_data} === e)
                else begin
                    miscompares++;
                    $error("FAIL rd_sb observed=%0h expected=%0h", {rd_index, rd_data}, e);
                end
            end
        end
        if (rst_n && wr_valid && wr_ready) begin
            vectors++;
            assert (wr_exp_q.size() != 0)
            else begin
                miscompares++;
                $error("FAIL wr_unexpected observed=%0h expected=none", wr_index);
            end
            if (wr_exp_q.size() != 0) begin
                logic [WR_W-1:0] e;
                e = wr_exp_q.pop_front();
                vectors++;
                assert (wr_index === e)
                else begin
                    miscompares++;
                    $error("FAIL wr_sb observed=%0h expected=%0h", wr_index, e);
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] d [3];
        int h;
        int order [10];

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_type  = REQ_READ;
        in_index = '0;
        in_data  = '0;
        rd_ready = 1'b1;
        wr_ready = 1'b1;
        step(2);

        // Reset state
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_rd_data",  32'(rd_data),  32'd0);
        chk("rst_rd_index", 32'(rd_index), 32'd0);
        chk("rst_wr_index", 32'(wr_index), 32'd0);
        chk("rst_rd_head",  32'(rd_head),  32'd0);
        chk("rst_wr_head",  32'(wr_head),  32'd0);
`ifdef RETURNER_CHECK_EN
        chk("rst_err_dup",  32'(err_dup),  32'd0);
`endif
        rst_n = 1'b1;
        step();

        // In-order reads: one-cycle latency, one per cycle
        for (int i = 0; i < 3; i++) begin
            d[i] = DW'($urandom_range(0, 16'hFFFF));
            push_rd(i, d[i]);
        end
        for (int i = 0; i < 3; i++) begin
            send(REQ_READ, i, d[i]);
            chk("inorder_valid", 32'(rd_valid), 32'd1);
            chk("inorder_index", 32'(rd_index), 32'(i));
            chk("inorder_data",  32'(rd_data),  32'(d[i]));
        end
        step();
        chk("inorder_idle", 32'(rd_valid), 32'd0);
        chk("inorder_head", 32'(rd_head),  32'd3);

        // Reverse arrival: blocked until head arrives, then back-to-back
        h = 32'(rd_head);
        for (int i = 0; i < 4; i++) push_rd((h + i) % RE, DW'(16'hA0 + i));
        for (int i = 3; i >= 1; i--) begin
            send(REQ_READ, (h + i) % RE, DW'(16'hA0 + i));
            chk("rev_blocked", 32'(rd_valid), 32'd0);
        end
        send(REQ_READ, h, 16'h00A0);
        chk("rev_bypass_data", 32'(rd_data), 32'h00A0);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("rev_valid", 32'(rd_valid), 32'd1);
            chk("rev_data",  32'(rd_data),  32'(16'hA0 + i));
        end
        step();
        chk("rev_idle", 32'(rd_valid), 32'd0);

        // Read stall with full window; writes keep retiring
        h = 32'(rd_head);
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_rd((h + i) % RE, DW'(16'hB0 + i));
        for (int i = 0; i < 4; i++) send(REQ_READ, (h + i) % RE, DW'(16'hB0 + i));
        wr_exp_q.push_back(3'd0);
        wr_exp_q.push_back(3'd1);
        send(REQ_WRITE, 0, DW'($urandom_range(0, 16'hFFFF)));
        chk("stall_wr0_valid", 32'(wr_valid), 32'd1);
        chk("stall_wr0_index", 32'(wr_index), 32'd0);
        send(REQ_WRITE, 1, DW'($urandom_range(0, 16'hFFFF)));
        chk("stall_wr1_index", 32'(wr_index), 32'd1);
        for (int c = 0; c < 5; c++) begin
            chk("stall_rd_valid", 32'(rd_valid), 32'd1);
            chk("stall_rd_data",  32'(rd_data),  32'h00B0);
            chk("stall_rd_head",  32'(rd_head),  32'((h + 1) % RE));
            step();
        end
        rd_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            chk("stall_release_data", 32'(rd_data), 32'(16'hB0 + i));
        end
        drain(10);

        // Reset with pending reads and a held output
        h = 32'(rd_head);
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(REQ_READ, (h + i) % RE, DW'(16'hD0 + i));
        chk("prerst_rd_valid", 32'(rd_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("asyncrst_rd_valid", 32'(rd_valid), 32'd0);
        chk("asyncrst_rd_data",  32'(rd_data),  32'd0);
        chk("asyncrst_rd_index", 32'(rd_index), 32'd0);
        chk("asyncrst_rd_head",  32'(rd_head),  32'd0);
        chk("asyncrst_wr_head",  32'(wr_head),  32'd0);
        rd_exp_q.delete();
        step(2);
        rst_n = 1'b1;
        rd_ready = 1'b1;
        step(2);
        chk("postrst_no_stale", 32'(rd_valid), 32'd0);

        // Wrap through a 4-deep window, pairwise-swapped arrival order
        order = '{1, 0, 3, 2, 5, 4, 7, 6, 9, 8};
        for (int n = 0; n < 10; n++) push_rd(n % RE, DW'(16'hC0 + n));
        send(REQ_READ, order[0] % RE, DW'(16'hC0 + order[0]));
        chk("wrap_first_blocked", 32'(rd_valid), 32'd0);
        send(REQ_READ, order[1] % RE, DW'(16'hC0 + order[1]));
        chk("wrap_idx0_first", 32'(rd_index), 32'd0);
        for (int k = 2; k < 10; k++) send(REQ_READ, order[k] % RE, DW'(16'hC0 + order[k]));
        drain(10);
        step();
        chk("wrap_head_end", 32'(rd_head), 32'd2);

        // Write ordering behind an empty head, duplicate detection
        for (int i = 0; i < 6; i++) wr_exp_q.push_back(WR_W'(i));
        send(REQ_WRITE, 5, DW'($urandom_range(0, 16'hFFFF)));
        chk("wr_head_blocks", 32'(wr_valid), 32'd0);
`ifdef RETURNER_CHECK_EN
        chk("dup_clear_first", 32'(err_dup), 32'd0);
        send(REQ_WRITE, 5, DW'($urandom_range(0, 16'hFFFF)));
        chk("dup_set", 32'(err_dup), 32'd1);
`endif
        for (int i = 0; i < 5; i++) send(REQ_WRITE, i, DW'($urandom_range(0, 16'hFFFF)));
        drain(10);
        step();
        chk("wr_head_end", 32'(wr_head), 32'd6);
        chk("wr_idle", 32'(wr_valid), 32'd0);
`ifdef RETURNER_CHECK_EN
        chk("dup_sticky", 32'(err_dup), 32'd1);
        rst_n = 1'b0;
        step();
        chk("dup_reset", 32'(err_dup), 32'd0);
        rst_n = 1'b1;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
